// File: rtl/crp16_step_controller.sv
// CRP16 single-step / free-run clock-enable controller.
// Debounced pushbutton stepping, divided free-run, halt handling.
module crp16_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 5000000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_key_n,
  input  logic        i_run_sw,
  input  logic        i_halt,
  output logic        o_step_en,
  output logic        o_running,
  output logic        o_halted,
  output logic [15:0] o_step_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int DVW = $clog2(RUN_DIV);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_key_s1;
  logic           r_key_s2;
  logic           r_rs_s1;
  logic           r_rs_s2;
  logic           r_key_db;
  logic           r_key_db_d;
  logic [DBW-1:0] r_db_cnt;
  logic [DVW-1:0] r_div;
  logic [DVW-1:0] w_div_nxt;
  logic           r_step_en;
  logic           w_step_nxt;
  logic           r_running;
  logic           r_halted;
  logic [15:0]    r_step_count;
  logic           w_press;
  logic           w_db_tc;

  assign w_db_tc = (r_db_cnt == DBW'(DEBOUNCE_CYCLES - 1));
  assign w_press = r_key_db_d & ~r_key_db;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_key_s1   <= 1'b1;
      r_key_s2   <= 1'b1;
      r_rs_s1    <= 1'b0;
      r_rs_s2    <= 1'b0;
      r_key_db   <= 1'b1;
      r_key_db_d <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_key_s1   <= i_key_n;
      r_key_s2   <= r_key_s1;
      r_rs_s1    <= i_run_sw;
      r_rs_s2    <= r_rs_s1;
      r_key_db_d <= r_key_db;
      if (r_key_s2 == r_key_db) begin
        r_db_cnt <= '0;
      end else if (w_db_tc) begin
        r_key_db <= r_key_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // halt outranks everything; leaving RUN always zeroes the divider
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = 1'b0;
    w_div_nxt   = '0;
    unique case (r_state)
      ST_STOPPED: begin
        if (i_halt)
          w_state_nxt = ST_HALTED;
        else if (r_rs_s2)
          w_state_nxt = ST_RUN;
        else if (w_press)
          w_step_nxt = 1'b1;
      end
      ST_RUN: begin
        if (i_halt)
          w_state_nxt = ST_HALTED;
        else if (!r_rs_s2)
          w_state_nxt = ST_STOPPED;
        else if (r_div == DVW'(RUN_DIV - 1))
          w_step_nxt = 1'b1;
        else
          w_div_nxt = r_div + 1'b1;
      end
      ST_HALTED: begin
        if (!r_rs_s2)
          w_state_nxt = ST_STOPPED;
      end
      default: w_state_nxt = ST_STOPPED;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_STOPPED;
      r_div        <= '0;
      r_step_en    <= 1'b0;
      r_running    <= 1'b0;
      r_halted     <= 1'b0;
      r_step_count <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_step_en <= w_step_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_halted  <= (w_state_nxt == ST_HALTED);
      if (r_step_en)
        r_step_count <= r_step_count + 16'd1;
    end
  end

  assign o_step_en    = r_step_en;
  assign o_running    = r_running;
  assign o_halted     = r_halted;
  assign o_step_count = r_step_count;

endmodule

// File: tb/tb_crp16_step_controller.sv
// Randomized bench for crp16_step_controller.
// Reference model tracks mode, debounce run length and run phase.
module tb_crp16_step_controller;

  localparam int D  = 4;
  localparam int RD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_n = 1'b1;
  logic        run_sw = 1'b0;
  logic        halt = 1'b0;
  logic        step_en;
  logic        running;
  logic        halted;
  logic [15:0] step_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crp16_step_controller #(
    .DEBOUNCE_CYCLES(D),
    .RUN_DIV(RD)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_key_n(key_n),
    .i_run_sw(run_sw),
    .i_halt(halt),
    .o_step_en(step_en),
    .o_running(running),
    .o_halted(halted),
    .o_step_count(step_count)
  );

  // model: mode 0=stopped 1=run 2=halted
  logic        kh0, kh1, rh0, rh1;
  logic        m_db, m_pend, m_step, prev_se;
  int          m_run, m_mode, m_phase;
  logic [15:0] m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, k, rs, h);
    logic ks, rss, pend, nstep;
    if (r) begin
      kh0 = 1; kh1 = 1; rh0 = 0; rh1 = 0;
      m_db = 1; m_pend = 0; m_step = 0;
      m_run = 0; m_mode = 0; m_phase = 0;
      m_cnt = 16'h0000;
    end else begin
      ks  = kh1;
      rss = rh1;
      kh1 = kh0; kh0 = k;
      rh1 = rh0; rh0 = rs;
      m_cnt = m_cnt + 16'(m_step);
      pend  = m_pend;
      nstep = 0;
      case (m_mode)
        0: begin
          if (h) m_mode = 2;
          else if (rss) begin m_mode = 1; m_phase = 0; end
          else if (pend) nstep = 1;
        end
        1: begin
          if (h) m_mode = 2;
          else if (!rss) m_mode = 0;
          else begin
            m_phase++;
            if (m_phase % RD == 0) nstep = 1;
          end
        end
        default: if (!rss) m_mode = 0;
      endcase
      m_step = nstep;
      m_pend = 0;
      if (ks != m_db) begin
        if (m_run == D - 1) begin
          m_db = ks; m_run = 0; m_pend = (ks == 1'b0);
        end else m_run++;
      end else m_run = 0;
    end
  endtask

  task automatic tick(input logic r, k, rs, h);
    rst = r; key_n = k; run_sw = rs; halt = h;
    @(posedge clk);
    model(r, k, rs, h);
    #1;
    chk("step_en", step_en, m_step);
    chk("running", running, m_mode == 1);
    chk("halted", halted, m_mode == 2);
    chk("step_count", step_count, m_cnt);
    chk("back_to_back", step_en & prev_se, 1'b0);
    prev_se = step_en;
  endtask

  initial begin
    int first;
    int bp[7];
    logic k, rs, h, r;
    prev_se = 0;
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);

    first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(0, 0, 0, 0);
      if (step_en && first < 0) first = i;
    end
    chk("press_latency", first, D + 3);
    repeat (20) tick(0, 1, 0, 0);
    chk("one_press_count", step_count, 1);

    tick(1, 1, 0, 0);
    bp = '{0, 1, 0, 1, 0, 0, 0};
    foreach (bp[i]) tick(0, bp[i][0], 0, 0);
    repeat (20) tick(0, 1, 0, 0);
    chk("bounce_count", step_count, 0);

    tick(1, 1, 0, 0);
    repeat (3) tick(0, 1, 1, 0);
    chk("run_latency", running, 1);
    repeat (5 * RD + 1) tick(0, 1, 1, 0);
    chk("run_5_pulses", step_count, 5);
    repeat (10) tick(0, 1, 0, 0);
    chk("run_stopped", running, 0);
    chk("run_stop_count", step_count, 5);

    for (int i = 0; i < 40; i++)
      if (!(m_mode == 1 && (m_phase + 1) % RD == 0))
        tick(0, 1, 1, 0);
    tick(0, 1, 1, 1);
    chk("halt_tc_pulse", step_en, 0);
    chk("halt_tc_halted", halted, 1);
    first = int'(step_count);
    repeat (15) tick(0, 0, 1, 0);
    repeat (15) tick(0, 1, 1, 0);
    chk("halted_press", step_count, first);
    repeat (4) tick(0, 1, 0, 0);
    chk("halt_exit", halted, 0);

    m_cnt = 16'hFFFF;
    force dut.r_step_count = 16'hFFFF;
    tick(0, 1, 0, 0);
    release dut.r_step_count;
    repeat (20) tick(0, 0, 0, 0);
    repeat (10) tick(0, 1, 0, 0);
    chk("count_wrap", step_count, 16'h0000);

    tick(1, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("rst_mid_count", step_count, 0);
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(0, 0, 0, 0);
      if (step_en && first < 0) first = i;
    end
    chk("rst_fresh_window", first, D + 3);

    k = 1; rs = 0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(5) == 0) k = ~k;
      if ($urandom_range(199) == 0) rs = ~rs;
      h = ($urandom_range(49) == 0);
      r = ($urandom_range(499) == 0);
      tick(r, k, rs, h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
